// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared types and constants for the queued UART command transmitter
package uart_cmd_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, GAP} tx_state_t;
  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_e;
  localparam int BAUD_DIV_19200 = 2604;
endpackage

// File: rtl/uart_cmd_queue_tx_fifo.sv
// cmd_sync_fifo: synchronous FIFO with registered full/empty/count and a drop-on-full overflow pulse
module cmd_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_nx;
  logic push, pop;
  assign push = wr_en && !full;
  assign pop = rd_en && !empty;
  assign count_nx = count + CW'(push) - CW'(pop);
  assign rd_data = mem[rd_ptr];
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      full <= 1'b0;
      empty <= 1'b1;
      ovf <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count_nx;
      full <= count_nx == CW'(DEPTH);
      empty <= count_nx == '0;
      ovf <= wr_en && full;
    end
endmodule

// File: rtl/uart_cmd_queue_tx.sv
// uart_cmd_queue_tx: FIFO-buffered UART transmitter that serialises queued command words back-to-back
module uart_cmd_queue_tx
  import uart_cmd_pkg::*;
#(
  parameter int BAUD_DIV  = BAUD_DIV_19200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int GAP_BITS  = 0,
  parameter int DEPTH     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [DATA_BITS-1:0]       wr_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       ovf,
  output logic                       TX,
  output logic                       busy,
  output logic                       tx_done,
  output logic                       all_done
);
  localparam int M1 = DATA_BITS > STOP_BITS ? DATA_BITS : STOP_BITS;
  localparam int MAXB = M1 > GAP_BITS ? M1 : GAP_BITS;
  localparam int BW = $clog2(MAXB);
  localparam int BCW = $clog2(BAUD_DIV);
  localparam logic [BCW-1:0] BAUD_LAST = BCW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic [BW-1:0] GAP_LAST = BW'(GAP_BITS - 1);
  localparam parity_e PMODE = parity_e'(PARITY);
  tx_state_t state;
  logic [BCW-1:0] baud;
  logic [BW-1:0] bitc;
  logic [DATA_BITS-1:0] shreg, head;
  logic par_bit, bit_end, pop;
  assign bit_end = baud == BAUD_LAST;
  assign pop = state == IDLE && !empty;
  assign all_done = empty && !busy;
  cmd_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(pop), .rd_data(head),
    .full(full), .empty(empty), .count(count), .ovf(ovf)
  );
  // TX is driven from the registered state, so the line trails the FSM by one clock
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      baud <= '0;
      bitc <= '0;
      shreg <= '0;
      par_bit <= 1'b0;
      busy <= 1'b0;
      tx_done <= 1'b0;
      TX <= 1'b1;
    end else begin
      tx_done <= 1'b0;
      TX <= (state == START) ? 1'b0 : (state == DATA) ? shreg[0] : (state == PAR) ? par_bit : 1'b1;
      baud <= (state == IDLE || bit_end) ? '0 : baud + 1'b1;
      case (state)
        IDLE: if (!empty) begin
          shreg <= head;
          par_bit <= (PMODE == PAR_ODD) ? ~^head : ^head;
          bitc <= '0;
          busy <= 1'b1;
          state <= START;
        end
        START: if (bit_end) state <= DATA;
        DATA: if (bit_end) begin
          shreg <= shreg >> 1;
          bitc <= (bitc == DATA_LAST) ? '0 : bitc + 1'b1;
          if (bitc == DATA_LAST) state <= (PMODE != PAR_NONE) ? PAR : STOP;
        end
        PAR: if (bit_end) state <= STOP;
        STOP: if (bit_end) begin
          bitc <= (bitc == STOP_LAST) ? '0 : bitc + 1'b1;
          if (bitc == STOP_LAST) begin
            tx_done <= 1'b1;
            busy <= GAP_BITS != 0;
            state <= (GAP_BITS != 0) ? GAP : IDLE;
          end
        end
        GAP: if (bit_end) begin
          bitc <= (bitc == GAP_LAST) ? '0 : bitc + 1'b1;
          if (bitc == GAP_LAST) begin
            busy <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_cmd_queue_tx.sv
// tb_uart_cmd_queue_tx: four differently configured instances driven by a vector table and corner-case sequences
module tb_uart_cmd_queue_tx;
  localparam int B = 16;
  localparam int PAR_T [4] = '{0, 0, 1, 2};
  localparam int STOP_T [4] = '{1, 1, 2, 1};
  localparam int GAP_T [4] = '{0, 0, 3, 0};
  localparam int DEP_T [4] = '{8, 4, 8, 8};
  typedef struct { int i; logic [7:0] d; logic p; } vec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0][7:0] wd = '0;
  logic [3:0] we = '0;
  logic [3:0] full, empty, ovf, tx, busy, tx_done, all_done;
  logic [3:0][3:0] cnt;
  int dcnt [4] = '{0, 0, 0, 0};
  int cyc = 0, n_tests = 0, n_fail = 0;
  int t0, t1, d0, lows;
  vec_t vec [8];
  int ec3 [6] = '{1, 1, 2, 3, 4, 4};
  logic [7:0] w3 [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

  for (genvar g = 0; g < 4; g++) begin : gi
    logic [$clog2(DEP_T[g]+1)-1:0] c;
    uart_cmd_queue_tx #(.BAUD_DIV(B), .DATA_BITS(8), .PARITY(PAR_T[g]), .STOP_BITS(STOP_T[g]),
                        .GAP_BITS(GAP_T[g]), .DEPTH(DEP_T[g])) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(we[g]), .wr_data(wd[g]), .full(full[g]), .empty(empty[g]),
      .count(c), .ovf(ovf[g]), .TX(tx[g]), .busy(busy[g]), .tx_done(tx_done[g]), .all_done(all_done[g])
    );
    assign cnt[g] = 4'(c);
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) for (int k = 0; k < 4; k++) if (tx_done[k]) dcnt[k] <= dcnt[k] + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int i, input logic [7:0] d);
    wd[i] = d;
    we[i] = 1'b1;
    @(negedge clk);
    we[i] = 1'b0;
  endtask

  // RX model: find the start bit, then sample every bit near its middle
  task automatic frame(input int i, input logic [7:0] d, input logic p, output int ts);
    int n;
    logic [7:0] r;
    n = 0;
    ts = 0;
    while (tx[i] !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("u%0d start seen", i), 32'(n < 400), 32'd1);
    if (n >= 400) return;
    ts = cyc;
    repeat (7) @(negedge clk);
    chk($sformatf("u%0d start bit", i), 32'(tx[i]), 32'd0);
    for (int b = 0; b < 8; b++) begin
      repeat (B) @(negedge clk);
      r[b] = tx[i];
    end
    chk($sformatf("u%0d data", i), 32'(r), 32'(d));
    if (PAR_T[i] != 0) begin
      repeat (B) @(negedge clk);
      chk($sformatf("u%0d parity", i), 32'(tx[i]), 32'(p));
    end
    for (int s = 0; s < STOP_T[i]; s++) begin
      repeat (B) @(negedge clk);
      chk($sformatf("u%0d stop%0d", i, s), 32'(tx[i]), 32'd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec[0] = '{0, 8'h3C, 1'b0};
    vec[1] = '{1, 8'h5A, 1'b0};
    vec[2] = '{2, 8'h07, 1'b1};
    vec[3] = '{2, 8'h81, 1'b0};
    vec[4] = '{2, 8'hFF, 1'b0};
    vec[5] = '{3, 8'h07, 1'b0};
    vec[6] = '{3, 8'h00, 1'b1};
    vec[7] = '{3, 8'hFE, 1'b0};
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("u%0d rst tx", k), 32'(tx[k]), 32'd1);
      chk($sformatf("u%0d rst busy", k), 32'(busy[k]), 32'd0);
      chk($sformatf("u%0d rst tx_done", k), 32'(tx_done[k]), 32'd0);
      chk($sformatf("u%0d rst ovf", k), 32'(ovf[k]), 32'd0);
      chk($sformatf("u%0d rst count", k), 32'(cnt[k]), 32'd0);
      chk($sformatf("u%0d rst empty", k), 32'(empty[k]), 32'd1);
      chk($sformatf("u%0d rst full", k), 32'(full[k]), 32'd0);
      chk($sformatf("u%0d rst all_done", k), 32'(all_done[k]), 32'd1);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single word: latency to start bit and frame shape
    d0 = dcnt[0];
    push(0, 8'hA5);
    chk("t1 count", 32'(cnt[0]), 32'd1);
    chk("t1 all_done low", 32'(all_done[0]), 32'd0);
    @(negedge clk);
    chk("t1 tx at N+1", 32'(tx[0]), 32'd1);
    chk("t1 busy", 32'(busy[0]), 32'd1);
    chk("t1 empty after pop", 32'(empty[0]), 32'd1);
    @(negedge clk);
    chk("t1 tx at N+2", 32'(tx[0]), 32'd0);
    frame(0, 8'hA5, 1'b0, t0);
    repeat (20) @(negedge clk);
    chk("t1 tx_done pulses", 32'(dcnt[0] - d0), 32'd1);
    chk("t1 all_done", 32'(all_done[0]), 32'd1);

    for (int k = 0; k < 8; k++) begin
      d0 = dcnt[vec[k].i];
      push(vec[k].i, vec[k].d);
      frame(vec[k].i, vec[k].d, vec[k].p, t0);
      repeat (70) @(negedge clk);
      chk($sformatf("vec%0d tx_done", k), 32'(dcnt[vec[k].i] - d0), 32'd1);
      chk($sformatf("vec%0d all_done", k), 32'(all_done[vec[k].i]), 32'd1);
      chk($sformatf("vec%0d busy", k), 32'(busy[vec[k].i]), 32'd0);
      chk($sformatf("vec%0d tx idle", k), 32'(tx[vec[k].i]), 32'd1);
    end

    // push and pop in the same cycle while count is 1
    push(3, 8'h5B);
    chk("t6 count first", 32'(cnt[3]), 32'd1);
    push(3, 8'hC3);
    chk("t6 count held", 32'(cnt[3]), 32'd1);
    chk("t6 no ovf", 32'(ovf[3]), 32'd0);
    frame(3, 8'h5B, 1'b0, t0);
    frame(3, 8'hC3, 1'b1, t0);
    repeat (30) @(negedge clk);
    chk("t6 all_done", 32'(all_done[3]), 32'd1);

    // three words queued behind a frame already on the line
    d0 = dcnt[0];
    push(0, 8'hFF);
    repeat (2) @(negedge clk);
    wd[0] = 8'h12; we[0] = 1'b1; @(negedge clk);
    chk("t2 count 1", 32'(cnt[0]), 32'd1);
    wd[0] = 8'h34; @(negedge clk);
    chk("t2 count 2", 32'(cnt[0]), 32'd2);
    wd[0] = 8'h56; @(negedge clk);
    chk("t2 count 3", 32'(cnt[0]), 32'd3);
    we[0] = 1'b0;
    frame(0, 8'hFF, 1'b0, t0);
    frame(0, 8'h12, 1'b0, t0);
    frame(0, 8'h34, 1'b0, t0);
    frame(0, 8'h56, 1'b0, t0);
    repeat (30) @(negedge clk);
    chk("t2 tx_done pulses", 32'(dcnt[0] - d0), 32'd4);
    chk("t2 all_done", 32'(all_done[0]), 32'd1);

    // overflow on a 4-deep queue
    d0 = dcnt[1];
    for (int k = 0; k < 6; k++) begin
      wd[1] = w3[k];
      we[1] = 1'b1;
      @(negedge clk);
      chk($sformatf("t3 count %0d", k), 32'(cnt[1]), 32'(ec3[k]));
      chk($sformatf("t3 full %0d", k), 32'(full[1]), 32'(k >= 4));
      chk($sformatf("t3 ovf %0d", k), 32'(ovf[1]), 32'(k == 5));
    end
    we[1] = 1'b0;
    @(negedge clk);
    chk("t3 ovf one pulse", 32'(ovf[1]), 32'd0);
    chk("t3 count after drop", 32'(cnt[1]), 32'd4);
    for (int k = 0; k < 5; k++) frame(1, w3[k], 1'b0, t0);
    repeat (30) @(negedge clk);
    chk("t3 tx_done pulses", 32'(dcnt[1] - d0), 32'd5);
    chk("t3 all_done", 32'(all_done[1]), 32'd1);

    // start-to-start spacing with parity, two stop bits and a three-bit gap
    push(2, 8'h07);
    push(2, 8'h81);
    frame(2, 8'h07, 1'b1, t0);
    frame(2, 8'h81, 1'b0, t1);
    chk("t4 start to start", 32'(t1 - t0), 32'(12 * B + 3 * B + 1));
    repeat (70) @(negedge clk);
    chk("t4 all_done", 32'(all_done[2]), 32'd1);

    // reset in the middle of the second of three queued frames
    d0 = dcnt[0];
    push(0, 8'hF0);
    push(0, 8'h00);
    push(0, 8'h77);
    frame(0, 8'hF0, 1'b0, t0);
    repeat (40) @(negedge clk);
    chk("t5 tx low before reset", 32'(tx[0]), 32'd0);
    chk("t5 count before reset", 32'(cnt[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5 tx after reset", 32'(tx[0]), 32'd1);
    chk("t5 count after reset", 32'(cnt[0]), 32'd0);
    chk("t5 busy after reset", 32'(busy[0]), 32'd0);
    chk("t5 all_done after reset", 32'(all_done[0]), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    repeat (400) begin
      @(negedge clk);
      if (tx[0] !== 1'b1) lows++;
    end
    chk("t5 no residual frame", 32'(lows), 32'd0);
    chk("t5 tx_done count", 32'(dcnt[0] - d0), 32'd1);
    chk("t5 count stays 0", 32'(cnt[0]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
